// File: rtl/i2s_rx_sampler_if.sv
// rtl/i2s_rx_sampler_if.sv - I2S receive pin bundle and stereo pair handshake
//
// Purpose: groups the I2S pins, the control strobes and the stereo
// sample-pair valid/ready handshake of i2s_rx_sampler into one bundle.
//
// Signals:
//   SCLK, LRCLK, DIN   I2S bit clock, word select (0 = left) and data from the
//                      codec; all asynchronous to the system clock
//   enable             1 = capture, 0 = resynchronise and drop partial words
//   frame_ready        consumer accepts the presented pair
//   clear_err          clears the sticky error flags
//   sample_left/right  presented stereo pair, stable while frame_valid = 1
//   frame_valid        a pair is presented
//   overrun            sticky: a completed pair was dropped
//   short_word         sticky: a slot ended with fewer than SAMPLE_WIDTH bits
//
// Modports: master = stimulus/consumer side, slave = sampler side.

interface i2s_rx_sampler_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    SCLK;
  logic                    LRCLK;
  logic                    DIN;
  logic                    enable;
  logic                    frame_ready;
  logic                    clear_err;
  logic [SAMPLE_WIDTH-1:0] sample_left;
  logic [SAMPLE_WIDTH-1:0] sample_right;
  logic                    frame_valid;
  logic                    overrun;
  logic                    short_word;

  modport master (
    output SCLK, LRCLK, DIN, enable, frame_ready, clear_err,
    input  sample_left, sample_right, frame_valid, overrun, short_word
  );

  modport slave (
    input  SCLK, LRCLK, DIN, enable, frame_ready, clear_err,
    output sample_left, sample_right, frame_valid, overrun, short_word
  );
endinterface

// File: rtl/i2s_rx_sampler.sv
// rtl/i2s_rx_sampler.sv - I2S receiver converting codec DOUT into stereo sample pairs
//
// Purpose: synchronises the asynchronous I2S pins into the Clk domain, tracks
// the one-bit-delayed I2S slot framing, assembles MSB-first channel words and
// presents left/right pairs through a valid/ready handshake.
//
// Ports:
//   Clk      system clock, must be at least 4x SCLK
//   Reset_n  asynchronous active-low reset
//   bus      i2s_rx_sampler_if.slave: I2S pins, enable, frame_ready,
//            clear_err in; sample_left/right, frame_valid, overrun,
//            short_word out
//
// Parameters:
//   SAMPLE_WIDTH   bits captured per channel word (8..24)
//   MAX_SLOT_BITS  maximum SCLK periods per slot; sizes the bit counter

module i2s_rx_sampler #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int MAX_SLOT_BITS = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  i2s_rx_sampler_if.slave bus
);

  localparam int              CW      = $clog2(MAX_SLOT_BITS);
  localparam logic [CW:0]     SW_C    = (CW+1)'(SAMPLE_WIDTH);
  localparam logic [CW:0]     ONE_C   = (CW+1)'(1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_SLOT_BITS - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. SCLK gets a third flop for rising-edge detection; LRCLK
  // and DIN share the same two-flop depth so they line up with the detected
  // SCLK edge.
  // ---------------------------------------------------------------------------
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_lr_s1, r_lr_s2;
  logic r_din_s1, r_din_s2;
  logic r_lr_prev;

  logic w_sclk_rise;
  logic w_lr;
  logic w_d;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_lr        = r_lr_s2;
  assign w_d         = r_din_s2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_din_s1  <= 1'b0;
      r_din_s2  <= 1'b0;
      r_lr_prev <= 1'b0;
    end else begin
      r_sclk_s1 <= bus.SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_lr_s1   <= bus.LRCLK;
      r_lr_s2   <= r_lr_s1;
      r_din_s1  <= bus.DIN;
      r_din_s2  <= r_din_s1;
      if (w_sclk_rise) begin
        r_lr_prev <= w_lr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot framing FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0]           r_bit_cnt;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [SAMPLE_WIDTH-1:0] r_left_hold;
  logic [SAMPLE_WIDTH-1:0] r_right_hold;
  logic                    r_pair_pend;

  logic w_shift_en;
  logic w_cnt_inc;
  logic w_cnt_clr;
  logic w_fin_left;
  logic w_fin_right;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (!bus.enable) begin
      w_state_nx = ST_SYNC;
    end else if (w_sclk_rise) begin
      case (r_state)
        // Lock only on a right->left change so the first pair is complete.
        ST_SYNC:  if (r_lr_prev && !w_lr) w_state_nx = ST_LEFT;
        ST_LEFT:  if (w_lr)               w_state_nx = ST_RIGHT;
        ST_RIGHT: if (!w_lr)              w_state_nx = ST_LEFT;
        default:                          w_state_nx = ST_SYNC;
      endcase
    end
  end

  // Bits are kept only while fewer than SAMPLE_WIDTH have been taken; the
  // delayed LSB seen on the LRCLK change follows the same rule.
  logic w_cnt_lt_sw;
  assign w_cnt_lt_sw = ({1'b0, r_bit_cnt} < SW_C);

  always_comb begin
    w_shift_en  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_fin_left  = 1'b0;
    w_fin_right = 1'b0;
    if (bus.enable && w_sclk_rise) begin
      case (r_state)
        ST_SYNC: begin
          w_cnt_clr = r_lr_prev & ~w_lr;
        end
        ST_LEFT: begin
          w_shift_en = w_cnt_lt_sw;
          if (w_lr) begin
            w_fin_left = 1'b1;
            w_cnt_clr  = 1'b1;
          end else begin
            w_cnt_inc  = 1'b1;
          end
        end
        ST_RIGHT: begin
          w_shift_en = w_cnt_lt_sw;
          if (!w_lr) begin
            w_fin_right = 1'b1;
            w_cnt_clr   = 1'b1;
          end else begin
            w_cnt_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembly and finalisation. A short word is left-justified by shifting
  // out the stale upper bits and zero-filling the LSBs.
  // ---------------------------------------------------------------------------
  logic [SAMPLE_WIDTH-1:0] w_shift_nx;
  logic [CW:0]             w_nbits;
  logic [CW:0]             w_pad;
  logic [SAMPLE_WIDTH-1:0] w_word;
  logic                    w_short;

  assign w_shift_nx = w_shift_en ? {r_shift[SAMPLE_WIDTH-2:0], w_d} : r_shift;
  assign w_nbits    = w_cnt_lt_sw ? ({1'b0, r_bit_cnt} + ONE_C) : SW_C;
  assign w_pad      = SW_C - w_nbits;
  assign w_word     = w_shift_nx << w_pad;
  assign w_short    = (w_fin_left | w_fin_right) & (w_pad != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_right_hold <= '0;
      r_pair_pend  <= 1'b0;
    end else begin
      r_pair_pend <= w_fin_right;
      if (!bus.enable) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else begin
        if (w_fin_left || w_fin_right) begin
          r_shift <= '0;
        end else begin
          r_shift <= w_shift_nx;
        end
        if (w_cnt_clr) begin
          r_bit_cnt <= '0;
        end else if (w_cnt_inc && (r_bit_cnt != CNT_MAX)) begin
          r_bit_cnt <= r_bit_cnt + CNT_ONE;
        end
        if (w_fin_left) begin
          r_left_hold <= w_word;
        end
        if (w_fin_right) begin
          r_right_hold <= w_word;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Presentation: a finalised pair loads one cycle after the right word closes.
  // An accept in that same cycle frees the slot, so the new pair still loads.
  // ---------------------------------------------------------------------------
  logic [SAMPLE_WIDTH-1:0] r_sample_left;
  logic [SAMPLE_WIDTH-1:0] r_sample_right;
  logic                    r_frame_valid;
  logic                    r_overrun;
  logic                    r_short_word;

  logic w_load;
  logic w_drop;

  assign w_load = r_pair_pend & (~r_frame_valid | bus.frame_ready);
  assign w_drop = r_pair_pend &   r_frame_valid & ~bus.frame_ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_frame_valid  <= 1'b0;
      r_overrun      <= 1'b0;
      r_short_word   <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample_left  <= r_left_hold;
        r_sample_right <= r_right_hold;
        r_frame_valid  <= 1'b1;
      end else if (r_frame_valid && bus.frame_ready) begin
        r_frame_valid  <= 1'b0;
      end

      // Set events take priority over a simultaneous clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.clear_err) begin
        r_overrun <= 1'b0;
      end

      if (w_short) begin
        r_short_word <= 1'b1;
      end else if (bus.clear_err) begin
        r_short_word <= 1'b0;
      end
    end
  end

  assign bus.sample_left  = r_sample_left;
  assign bus.sample_right = r_sample_right;
  assign bus.frame_valid  = r_frame_valid;
  assign bus.overrun      = r_overrun;
  assign bus.short_word   = r_short_word;

endmodule
